alu_seq: RTL and testbench
==========================

# alu_seq

Parametrised multi-cycle successor to the single-cycle integer ALU, placed in the execute stage of the riscv-cpu datapath. It performs all RV32I ALU operations with one-cycle latency and adds the RV32M multiply/divide/remainder operations, computed iteratively over WORD_SIZE cycles. Operands enter and results leave through valid/ready handshakes, so the pipeline stalls on `in_ready`/`out_valid` instead of assuming a fixed latency.

## Interface
- `WORD_SIZE`, default 32: operand/result width; must be ≥ 8 and even.
- `SHAMT_W`, default $clog2(WORD_SIZE): shift-amount bits taken from `arg_b`.
- `clk` input, 1 bit: clock; all state updates on rising edge.
- `rst` input, 1 bit: synchronous, active-high reset.
- `in_valid` input, 1 bit: operands and `alu_sel` are valid.
- `in_ready` output, 1 bit: block can accept an operation.
- `arg_a` input, WORD_SIZE bits: operand A / dividend / multiplicand.
- `arg_b` input, WORD_SIZE bits: operand B / divisor / multiplier.
- `alu_sel` input, 5 bits: operation code.
- `out_valid` output, 1 bit: `alu_out` holds a completed result.
- `out_ready` input, 1 bit: consumer accepts the result.
- `alu_out` output, WORD_SIZE bits: registered result.
- `busy` output, 1 bit: iterative operation in progress.

## Operation
- Opcodes: 0x01 ADD, 0x02 SUB, 0x03 XOR, 0x04 OR, 0x05 AND, 0x06 SLL, 0x07 SRL, 0x08 SRA, 0x09 SLT, 0x0A SLTU, 0x10 MUL, 0x11 MULH, 0x12 MULHSU, 0x13 MULHU, 0x14 DIV, 0x15 DIVU, 0x16 REM, 0x17 REMU. Any other code gives result 0 via the base path.
- Base ops: shifts use `arg_b[SHAMT_W-1:0]`; SLT/SLTU return 1 or 0; arithmetic wraps modulo 2^WORD_SIZE.
- MUL returns the low word of the product. MULH, MULHSU and MULHU return the high word of the 2·WORD_SIZE product (signed×signed, signed×unsigned, unsigned×unsigned).
- Signed M ops work on operand magnitudes; the result is negated at the end if the signs require it.
- Divide by zero: DIV/DIVU give all-ones; REM/REMU give `arg_a`.
- Signed overflow (most-negative ÷ −1): DIV gives most-negative; REM gives 0.
- Division by zero and signed overflow complete with the normal latency; there is no early exit.
- FSM states and transitions:
  - IDLE: `in_ready`=1. On accept, a base op goes to DONE; an M op loads its operands and goes to CALC.
  - CALC: one shift-add (multiply) or restoring-subtract (divide) step per cycle. A counter runs from WORD_SIZE−1 to 0; at 0 the sign fix is applied and the FSM goes to DONE.
  - DONE: `out_valid`=1 and `alu_out` is held stable. On `out_ready`, go to IDLE.
- `in_ready` is 1 only in IDLE and never while `rst`=1. Inputs are sampled only on accept (`in_valid`&&`in_ready`); changes afterwards are ignored.

## Timing
- Reset values: state IDLE, `out_valid`=0, `alu_out`=0, `busy`=0, counter 0. `in_ready` is 0 during reset and 1 in the first cycle after it.
- Base-op latency: `out_valid` rises the cycle after accept.
- M-op latency: `out_valid` rises WORD_SIZE+1 cycles after accept. `busy`=1 exactly in the CALC cycles.
- Back-pressure: DONE holds until `out_ready`. The next accept can happen no earlier than the cycle after the handshake, so peak throughput is one op per 2 cycles.
- Reset during CALC or DONE aborts the operation; the result is discarded and no `out_valid` is produced.
- `in_valid` asserted outside IDLE is ignored. The upstream stage must hold its inputs until `in_ready`.

## Configuration
- `ALU_SEQ_MULDIV_EN` defined: multiply/divide datapath, counter and CALC state are present as described above.
- `ALU_SEQ_MULDIV_EN` undefined: opcodes 0x10–0x17 behave as unknown codes (result 0, one-cycle latency). CALC and the iterative datapath are removed, and `busy` is tied to 0.

## Structure
- Package `alu_pkg` holds the 5-bit opcode localparams, the FSM state enum (IDLE/CALC/DONE) and a helper function `is_muldiv(sel)`.
- Sub-module `muldiv_iter` holds the iterative multiply/divide datapath, the sign handling and the step counter. It has start/done strobes and is instantiated only under `ALU_SEQ_MULDIV_EN`.
- The top level holds the FSM, the handshakes, the combinational base-op logic and the output register.

## Test plan
- ADD 0x7FFFFFFF+1 with `out_ready`=1 → 0x80000000, `out_valid` on the cycle after accept; SRA 0x80000000 by 4 → 0xF8000000.
- MULH 0xFFFFFFFF×0xFFFFFFFF → 0x00000000; MULHU of the same operands → 0xFFFFFFFE; both arrive 33 cycles after accept with `busy` high for 32 cycles.
- DIV 0x80000000 ÷ 0xFFFFFFFF → 0x80000000; REM of the same → 0; DIVU 7 ÷ 0 → 0xFFFFFFFF; REMU 7 ÷ 0 → 7.
- DIV −7 ÷ 2 → 0xFFFFFFFD; REM −7 ÷ 2 → 0xFFFFFFFF.
- Hold `out_ready`=0 for 5 cycles after the result: `alu_out` stays stable, `in_ready`=0 and a new `in_valid` is ignored; release → one handshake, then IDLE.
- Assert `rst` mid-CALC, then issue ADD 2+3 → `out_valid` only for the ADD, result 5. Repeat with `ALU_SEQ_MULDIV_EN` undefined: MUL 3×4 → 0 after 1 cycle.

Source files
------------

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcode encodings, FSM state type and opcode classification for alu_seq
package alu_pkg;

    localparam logic [4:0] OP_ADD    = 5'h01;
    localparam logic [4:0] OP_SUB    = 5'h02;
    localparam logic [4:0] OP_XOR    = 5'h03;
    localparam logic [4:0] OP_OR     = 5'h04;
    localparam logic [4:0] OP_AND    = 5'h05;
    localparam logic [4:0] OP_SLL    = 5'h06;
    localparam logic [4:0] OP_SRL    = 5'h07;
    localparam logic [4:0] OP_SRA    = 5'h08;
    localparam logic [4:0] OP_SLT    = 5'h09;
    localparam logic [4:0] OP_SLTU   = 5'h0A;
    localparam logic [4:0] OP_MUL    = 5'h10;
    localparam logic [4:0] OP_MULH   = 5'h11;
    localparam logic [4:0] OP_MULHSU = 5'h12;
    localparam logic [4:0] OP_MULHU  = 5'h13;
    localparam logic [4:0] OP_DIV    = 5'h14;
    localparam logic [4:0] OP_DIVU   = 5'h15;
    localparam logic [4:0] OP_REM    = 5'h16;
    localparam logic [4:0] OP_REMU   = 5'h17;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    // The M extension occupies exactly 0x10..0x17.
    function automatic logic is_muldiv(input logic [4:0] sel);
        return sel[4:3] == 2'b10;
    endfunction

endpackage

// File: rtl/alu_seq_if.sv
// rtl/alu_seq_if.sv - operand/result valid-ready bundle between the pipeline and alu_seq
interface alu_seq_if #(
    parameter int WORD_SIZE = 32
);
    logic                 in_valid;
    logic                 in_ready;
    logic [WORD_SIZE-1:0] arg_a;
    logic [WORD_SIZE-1:0] arg_b;
    logic [4:0]           alu_sel;
    logic                 out_valid;
    logic                 out_ready;
    logic [WORD_SIZE-1:0] alu_out;
    logic                 busy;

    modport master (
        output in_valid, arg_a, arg_b, alu_sel, out_ready,
        input  in_ready, out_valid, alu_out, busy
    );

    modport slave (
        input  in_valid, arg_a, arg_b, alu_sel, out_ready,
        output in_ready, out_valid, alu_out, busy
    );
endinterface

// File: rtl/muldiv_iter.sv
// rtl/muldiv_iter.sv - iterative shift-add multiplier / restoring divider on operand magnitudes
// Only instantiated by alu_seq when ALU_SEQ_MULDIV_EN is defined.
module muldiv_iter
    import alu_pkg::*;
#(
    parameter int WORD_SIZE = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_i,
    input  logic [4:0]           sel_i,
    input  logic [WORD_SIZE-1:0] a_i,
    input  logic [WORD_SIZE-1:0] b_i,
    output logic                 done_o,
    output logic [WORD_SIZE-1:0] result_o
);
    localparam int W     = WORD_SIZE;
    localparam int CNT_W = $clog2(WORD_SIZE);

    // prod_q: {acc, multiplier} when multiplying, {remainder, quotient} when dividing
    logic [2*W-1:0]   prod_q, prod_d, step;
    logic [W-1:0]     opnd_q, opnd_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             active_q, active_d;
    logic [4:0]       op_q, op_d;
    logic             neg_q, neg_d;

    logic             is_div, a_signed, b_signed, sa, sb, neg_start;
    logic [W-1:0]     mag_a, mag_b;
    logic             op_is_div, ge;
    logic [W:0]       sum, rshift;
    logic [2*W-1:0]   full;

    always_comb begin
        is_div   = sel_i inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
        a_signed = sel_i inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
        b_signed = sel_i inside {OP_MUL, OP_MULH, OP_DIV, OP_REM};
        sa       = a_signed & a_i[W-1];
        sb       = b_signed & b_i[W-1];
        mag_a    = sa ? -a_i : a_i;
        mag_b    = sb ? -b_i : b_i;
        // Quotient of a divide-by-zero stays all-ones; remainder follows the dividend.
        if (sel_i == OP_DIV) begin
            neg_start = (sa ^ sb) && (b_i != '0);
        end else if (sel_i == OP_REM) begin
            neg_start = sa;
        end else begin
            neg_start = sa ^ sb;
        end
    end

    always_comb begin
        op_is_div = op_q inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
        sum       = {1'b0, prod_q[2*W-1:W]};
        if (prod_q[0]) begin
            sum = sum + {1'b0, opnd_q};
        end
        rshift = {prod_q[2*W-1:W], prod_q[W-1]};
        ge     = rshift >= {1'b0, opnd_q};
        if (op_is_div) begin
            step = ge ? {W'(rshift - {1'b0, opnd_q}), prod_q[W-2:0], 1'b1}
                      : {rshift[W-1:0], prod_q[W-2:0], 1'b0};
        end else begin
            step = {sum, prod_q[W-1:1]};
        end
        full = neg_q ? -step : step;
        case (op_q)
            OP_MUL:          result_o = full[W-1:0];
            OP_DIV, OP_DIVU: result_o = neg_q ? -step[W-1:0] : step[W-1:0];
            OP_REM, OP_REMU: result_o = neg_q ? -step[2*W-1:W] : step[2*W-1:W];
            default:         result_o = full[2*W-1:W];
        endcase
    end

    assign done_o = active_q && (cnt_q == '0);

    always_comb begin
        prod_d   = prod_q;
        opnd_d   = opnd_q;
        cnt_d    = cnt_q;
        active_d = active_q;
        op_d     = op_q;
        neg_d    = neg_q;
        if (start_i) begin
            active_d = 1'b1;
            cnt_d    = CNT_W'(W - 1);
            op_d     = sel_i;
            neg_d    = neg_start;
            prod_d   = {{W{1'b0}}, (is_div ? mag_a : mag_b)};
            opnd_d   = is_div ? mag_b : mag_a;
        end else if (active_q) begin
            prod_d = step;
            if (cnt_q == '0) begin
                active_d = 1'b0;
            end else begin
                cnt_d = cnt_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prod_q   <= '0;
            opnd_q   <= '0;
            cnt_q    <= '0;
            active_q <= 1'b0;
            op_q     <= '0;
            neg_q    <= 1'b0;
        end else begin
            prod_q   <= prod_d;
            opnd_q   <= opnd_d;
            cnt_q    <= cnt_d;
            active_q <= active_d;
            op_q     <= op_d;
            neg_q    <= neg_d;
        end
    end

endmodule

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - handshaked RV32I ALU with optional iterative RV32M unit
// Define ALU_SEQ_MULDIV_EN to build the multiply/divide datapath and CALC state.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WORD_SIZE = 32,
    parameter int SHAMT_W   = $clog2(WORD_SIZE)
) (
    input  logic       clk,
    input  logic       rst,
    alu_seq_if.slave   bus
);
    state_e               state_q, state_d;
    logic [WORD_SIZE-1:0] result_q, result_d, base_res;
    logic                 in_ready, accept, go_calc;
    logic                 md_done;
    logic [WORD_SIZE-1:0] md_result;
    logic [SHAMT_W-1:0]   shamt;

    assign in_ready      = (state_q == IDLE) && !rst;
    assign accept        = bus.in_valid && in_ready;
    assign bus.in_ready  = in_ready;
    assign bus.out_valid = (state_q == DONE);
    assign bus.alu_out   = result_q;
    assign shamt         = bus.arg_b[SHAMT_W-1:0];

    always_comb begin
        case (bus.alu_sel)
            OP_ADD:  base_res = bus.arg_a + bus.arg_b;
            OP_SUB:  base_res = bus.arg_a - bus.arg_b;
            OP_XOR:  base_res = bus.arg_a ^ bus.arg_b;
            OP_OR:   base_res = bus.arg_a | bus.arg_b;
            OP_AND:  base_res = bus.arg_a & bus.arg_b;
            OP_SLL:  base_res = bus.arg_a << shamt;
            OP_SRL:  base_res = bus.arg_a >> shamt;
            OP_SRA:  base_res = $signed(bus.arg_a) >>> shamt;
            OP_SLT:  base_res = {{(WORD_SIZE-1){1'b0}}, ($signed(bus.arg_a) < $signed(bus.arg_b))};
            OP_SLTU: base_res = {{(WORD_SIZE-1){1'b0}}, (bus.arg_a < bus.arg_b)};
            default: base_res = '0;
        endcase
    end

`ifdef ALU_SEQ_MULDIV_EN
    logic md_start;

    assign go_calc  = is_muldiv(bus.alu_sel);
    assign md_start = accept && go_calc;
    assign bus.busy = (state_q == CALC);

    muldiv_iter #(
        .WORD_SIZE (WORD_SIZE)
    ) u_muldiv (
        .clk      (clk),
        .rst      (rst),
        .start_i  (md_start),
        .sel_i    (bus.alu_sel),
        .a_i      (bus.arg_a),
        .b_i      (bus.arg_b),
        .done_o   (md_done),
        .result_o (md_result)
    );
`else
    // M opcodes fall through to the base path, which returns 0 for them.
    assign go_calc   = 1'b0;
    assign md_done   = 1'b0;
    assign md_result = '0;
    assign bus.busy  = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (go_calc) begin
                        state_d = CALC;
                    end else begin
                        result_d = base_res;
                        state_d  = DONE;
                    end
                end
            end
            CALC: begin
                if (md_done) begin
                    result_d = md_result;
                    state_d  = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - directed and randomized checks of alu_seq against an arithmetic reference model
module tb_alu_seq;
    import alu_pkg::*;

`ifdef ALU_SEQ_MULDIV_EN
    localparam bit MD = 1'b1;
`else
    localparam bit MD = 1'b0;
`endif
    localparam int W = 32;
    localparam logic [4:0] OPS [18] = '{5'h01, 5'h02, 5'h03, 5'h04, 5'h05, 5'h06, 5'h07, 5'h08, 5'h09,
                                       5'h0A, 5'h10, 5'h11, 5'h12, 5'h13, 5'h14, 5'h15, 5'h16, 5'h17};

    logic clk = 1'b0;
    logic rst;
    int   n_total = 0;
    int   n_pass  = 0;

    alu_seq_if #(.WORD_SIZE(W)) bus ();

    alu_seq #(.WORD_SIZE(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Reference semantics from plain 64-bit arithmetic.
    function automatic logic [31:0] ref_alu(input logic [4:0] sel, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] as64, au64, bs64, bu64, p;
        as64 = {{32{a[31]}}, a};
        au64 = {32'd0, a};
        bs64 = {{32{b[31]}}, b};
        bu64 = {32'd0, b};
        case (sel)
            5'h01: return a + b;
            5'h02: return a - b;
            5'h03: return a ^ b;
            5'h04: return a | b;
            5'h05: return a & b;
            5'h06: return a << b[4:0];
            5'h07: return a >> b[4:0];
            5'h08: return $signed(a) >>> b[4:0];
            5'h09: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            5'h0A: return (a < b) ? 32'd1 : 32'd0;
            default: ;
        endcase
        if (!MD) return 32'd0;
        case (sel)
            5'h10: begin p = as64 * bs64; return p[31:0]; end
            5'h11: begin p = as64 * bs64; return p[63:32]; end
            5'h12: begin p = as64 * bu64; return p[63:32]; end
            5'h13: begin p = au64 * bu64; return p[63:32]; end
            5'h14: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return $signed(a) / $signed(b);
            end
            5'h15: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            5'h16: begin
                if (b == 32'd0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                return $signed(a) % $signed(b);
            end
            5'h17: return (b == 32'd0) ? a : a % b;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] rnd_word();
        case ($urandom_range(0, 6))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return $urandom_range(0, 15);
            default: return $urandom;
        endcase
    endfunction

    // Called and returns at posedge+1.
    task automatic run_op(input logic [4:0] sel, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input string tag, input bit hold);
        int guard, lat, busy_cycles, exp_lat;
        exp_lat = (MD && sel[4:3] == 2'b10) ? W + 1 : 1;
        guard = 0;
        while (bus.in_ready !== 1'b1 && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        check({tag, " in_ready"}, {31'd0, bus.in_ready}, 32'd1);
        bus.in_valid = 1'b1;
        bus.alu_sel  = sel;
        bus.arg_a    = a;
        bus.arg_b    = b;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.alu_sel  = 5'($urandom);
        bus.arg_a    = $urandom;
        bus.arg_b    = $urandom;
        lat = 1;
        busy_cycles = 0;
        while (bus.out_valid !== 1'b1 && lat < 100) begin
            if (bus.busy === 1'b1) busy_cycles++;
            @(posedge clk); #1;
            lat++;
        end
        check({tag, " latency"}, 32'(lat), 32'(exp_lat));
        check({tag, " result"}, bus.alu_out, exp);
        check({tag, " busy_cycles"}, 32'(busy_cycles), 32'(exp_lat - 1));
        if (hold) begin
            for (int i = 0; i < 5; i++) begin
                bus.in_valid = 1'b1;
                bus.alu_sel  = OP_ADD;
                bus.arg_a    = $urandom;
                bus.arg_b    = $urandom;
                @(posedge clk); #1;
                check({tag, " hold alu_out"}, bus.alu_out, exp);
                check({tag, " hold in_ready"}, {31'd0, bus.in_ready}, 32'd0);
                check({tag, " hold out_valid"}, {31'd0, bus.out_valid}, 32'd1);
            end
            bus.in_valid = 1'b0;
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        check({tag, " post out_valid"}, {31'd0, bus.out_valid}, 32'd0);
        check({tag, " post in_ready"}, {31'd0, bus.in_ready}, 32'd1);
        if (hold) begin
            @(posedge clk); #1;
            check({tag, " no ghost op"}, {31'd0, bus.out_valid}, 32'd0);
        end
    endtask

    initial begin
        logic [4:0]  sel;
        logic [31:0] a, b;

        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.alu_sel   = 5'd0;
        bus.arg_a     = 32'd0;
        bus.arg_b     = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        check("reset in_ready", {31'd0, bus.in_ready}, 32'd0);
        check("reset out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("reset alu_out", bus.alu_out, 32'd0);
        check("reset busy", {31'd0, bus.busy}, 32'd0);
        rst = 1'b0;
        #1;
        check("post-reset in_ready", {31'd0, bus.in_ready}, 32'd1);

        run_op(OP_ADD, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, "add_wrap", 1'b0);
        run_op(OP_SRA, 32'h8000_0000, 32'd4, 32'hF800_0000, "sra", 1'b0);
        run_op(OP_MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, "mulh_m1", 1'b0);
        run_op(OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MD ? 32'hFFFF_FFFE : 32'd0, "mulhu_max", 1'b0);
        run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, MD ? 32'h8000_0000 : 32'd0, "div_ovf", 1'b1);
        run_op(OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, "rem_ovf", 1'b0);
        run_op(OP_DIVU, 32'd7, 32'd0, MD ? 32'hFFFF_FFFF : 32'd0, "divu_zero", 1'b0);
        run_op(OP_REMU, 32'd7, 32'd0, MD ? 32'd7 : 32'd0, "remu_zero", 1'b0);
        run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, MD ? 32'hFFFF_FFFD : 32'd0, "div_neg", 1'b0);
        run_op(OP_REM, 32'hFFFF_FFF9, 32'd2, MD ? 32'hFFFF_FFFF : 32'd0, "rem_neg", 1'b0);
        run_op(OP_MUL, 32'd3, 32'd4, MD ? 32'd12 : 32'd0, "mul_small", 1'b0);
        run_op(OP_ADD, 32'd5, 32'd9, 32'd14, "add_hold", 1'b1);

        // Abort an operation with reset, then make sure only the following ADD completes.
        bus.in_valid = 1'b1;
        bus.alu_sel  = OP_MUL;
        bus.arg_a    = 32'd3;
        bus.arg_b    = 32'd4;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (5) begin
            @(posedge clk); #1;
        end
        check("abort busy before reset", {31'd0, bus.busy}, {31'd0, MD});
        rst = 1'b1;
        #1;
        check("abort in_ready in reset", {31'd0, bus.in_ready}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("abort busy", {31'd0, bus.busy}, 32'd0);
        check("abort alu_out", bus.alu_out, 32'd0);
        begin
            int spurious;
            spurious = 0;
            for (int i = 0; i < 40; i++) begin
                @(posedge clk); #1;
                if (bus.out_valid !== 1'b0) spurious++;
            end
            check("abort no late out_valid", 32'(spurious), 32'd0);
        end
        run_op(OP_ADD, 32'd2, 32'd3, 32'd5, "add_after_abort", 1'b0);

        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 7) == 0) sel = 5'($urandom_range(0, 31));
            else sel = OPS[$urandom_range(0, 17)];
            a = rnd_word();
            b = rnd_word();
            run_op(sel, a, b, ref_alu(sel, a, b), $sformatf("rnd%0d sel=%h a=%h b=%h", n, sel, a, b), 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
